bcd_limit_counter: RTL
======================

BCD_LIMIT_COUNTER -- requirements
Module: bcd_limit_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits; legal range 1..8.
REQ-002 Parameter LIMIT, default 9675: terminal count, binary integer; legal range 0..(10^DIGITS - 1).
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the boundary, 1 = hold at the boundary.
REQ-004 Clocking and reset SHALL be as follows: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 ena  input  1  count enable; one step per clk cycle while high.
REQ-008 up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 clr  input  1  synchronous clear to zero.
REQ-010 load  input  1  synchronous load of load_data.
REQ-011 load_data  input  4*DIGITS  packed BCD; digit 0 in bits [3:0].
REQ-012 Qdata  output  4*DIGITS  packed BCD count; digit 0 in bits [3:0].
REQ-013 digit_ena  output  DIGITS  combinational; bit i high when digit i changes on the next edge.
REQ-014 tc  output  1  registered one-cycle pulse on a boundary event.
REQ-015 at_limit  output  1  combinational; high while Qdata equals LIMIT.
REQ-016 at_zero  output  1  combinational; high while Qdata equals 0.
REQ-017 load_err  output  1  registered one-cycle pulse when a load is rejected.

Function
REQ-018 Edge priority SHALL be rst > clr > load > ena; only the highest active request acts.
REQ-019 clr SHALL set Qdata to 0 on the next edge, with no tc and no load_err.
REQ-020 load SHALL be accepted only if every digit is 0..9 and the value is <= LIMIT; accepted: Qdata = load_data on the next edge.
REQ-021 A rejected load SHALL leave Qdata unchanged, pulse load_err for one cycle, and suppress counting that cycle.
REQ-022 With ena=1 and up_dn=1 below LIMIT: Qdata SHALL increment by 1 in decimal, with digit i rolling 9->0 and carrying into digit i+1.
REQ-023 With ena=1 and up_dn=0 above 0: Qdata SHALL decrement by 1 in decimal, with digit i rolling 0->9 and borrowing from digit i+1.
REQ-024 Up count at LIMIT: SATURATE=0 SHALL load 0; SATURATE=1 SHALL hold LIMIT; both pulse tc on the following cycle.
REQ-025 Down count at 0: SATURATE=0 SHALL load LIMIT; SATURATE=1 SHALL hold 0; both pulse tc on the following cycle.
REQ-026 tc SHALL pulse once per boundary event; in saturate mode it repeats every cycle that ena remains high at the boundary.
REQ-027 digit_ena[0] SHALL equal ena & ~clr & ~load; digit_ena[i] SHALL additionally require every lower digit to be at its roll value (9 up, 0 down).
REQ-028 digit_ena SHALL be all-ones on a wrap and all-zero on a saturate hold.
REQ-029 A change of up_dn SHALL take effect on the same edge, with no dead cycle.
REQ-030 LIMIT=0 SHALL keep Qdata at 0, with tc pulsing on every enabled cycle.

Reset
REQ-031 rst high SHALL immediately force Qdata=0 and tc=0 and load_err=0, independent of clk.
REQ-032 Deassertion of rst SHALL be followed by normal operation from the first subsequent rising clk edge.
REQ-033 rst asserted mid-count or mid-load SHALL abort the operation, with no tc or load_err pulse afterwards.

Verification (DIGITS=4, LIMIT=9675 unless stated)
REQ-034 Reset, then ena=1 and up_dn=1 for 9676 cycles -> Qdata steps 0000..9675 then 0000; tc pulses exactly once, the cycle after the 9675->0000 edge.
REQ-035 Load 0099 then up one step -> Qdata=0100 and digit_ena=0111 in the cycle before the edge; then down one step -> 0099.
REQ-036 Load 0000 then down one step, SATURATE=0 -> Qdata=9675 and tc pulse; with SATURATE=1 -> Qdata holds 0000 and tc pulses each cycle.
REQ-037 load_data=9676 or 12A4 -> Qdata unchanged, load_err one-cycle pulse, no count that cycle.
REQ-038 clr, load and ena all high at Qdata=5000 -> Qdata=0000; clr released with load=1 and load_data=1234 -> Qdata=1234.
REQ-039 rst pulsed between clk edges while counting at 3456 -> Qdata=0000 immediately; counting resumes at 0001 on the first edge after release.

Source files
------------

// File: rtl/bcd_limit_counter.sv
// Up/down packed-BCD counter with a programmable terminal count, wrap or saturate
// at the boundaries, validated synchronous load and per-digit change enables.
module bcd_limit_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned LIMIT    = 9675,
    parameter int unsigned SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic [4*DIGITS-1:0]   Qdata,
    output logic [DIGITS-1:0]     digit_ena,
    output logic                  tc,
    output logic                  at_limit,
    output logic                  at_zero,
    output logic                  load_err
);

    function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned         x;
        r = '0;
        x = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

    localparam logic [4*DIGITS-1:0] LIMIT_BCD = to_bcd(LIMIT);

    logic [4*DIGITS-1:0] r_q;
    logic                r_tc;
    logic                r_load_err;

    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;
    logic [DIGITS-1:0]   w_up_chain;
    logic [DIGITS-1:0]   w_dn_chain;
    logic                w_load_ok;
    logic [4*DIGITS-1:0] w_next;
    logic [DIGITS-1:0]   w_digit_ena;
    logic                w_tc_next;
    logic                w_err_next;
    logic                w_at_limit;
    logic                w_at_zero;

    assign w_at_limit = (r_q == LIMIT_BCD);
    assign w_at_zero  = (r_q == '0);

    // Ripple carry/borrow per digit; the chain bit is also the digit's change enable.
    always_comb begin : bcd_step
        logic       c;
        logic       b;
        logic [3:0] d;
        w_inc      = r_q;
        w_dec      = r_q;
        w_up_chain = '0;
        w_dn_chain = '0;
        c          = 1'b1;
        b          = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d             = r_q[4*i +: 4];
            w_up_chain[i] = c;
            w_dn_chain[i] = b;
            if (c) w_inc[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
            if (b) w_dec[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
            c = c & (d == 4'd9);
            b = b & (d == 4'd0);
        end
    end

    // Digit-wise BCD compare equals numeric compare once every digit is 0..9.
    always_comb begin
        w_load_ok = (load_data <= LIMIT_BCD);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (load_data[4*i +: 4] > 4'd9) w_load_ok = 1'b0;
        end
    end

    always_comb begin
        w_next      = r_q;
        w_digit_ena = '0;
        w_tc_next   = 1'b0;
        w_err_next  = 1'b0;
        if (clr) begin
            w_next = '0;
        end else if (load) begin
            if (w_load_ok) w_next = load_data;
            else           w_err_next = 1'b1;
        end else if (ena) begin
            if (up_dn) begin
                if (w_at_limit) begin
                    w_tc_next   = 1'b1;
                    w_next      = (SATURATE != 0) ? r_q : '0;
                    w_digit_ena = (SATURATE != 0) ? '0 : '1;
                end else begin
                    w_next      = w_inc;
                    w_digit_ena = w_up_chain;
                end
            end else begin
                if (w_at_zero) begin
                    w_tc_next   = 1'b1;
                    w_next      = (SATURATE != 0) ? r_q : LIMIT_BCD;
                    w_digit_ena = (SATURATE != 0) ? '0 : '1;
                end else begin
                    w_next      = w_dec;
                    w_digit_ena = w_dn_chain;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q        <= '0;
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_q        <= w_next;
            r_tc       <= w_tc_next;
            r_load_err <= w_err_next;
        end
    end

    assign Qdata     = r_q;
    assign digit_ena = w_digit_ena;
    assign tc        = r_tc;
    assign load_err  = r_load_err;
    assign at_limit  = w_at_limit;
    assign at_zero   = w_at_zero;

endmodule
